// File: rtl/if_fetch.sv
// Instruction-fetch stage sitting directly in front of the memory controller.
// Owns the architectural PC and uses the controller's same-cycle icache result.
// On a miss it requests the word from the controller. It presents
// {if_pc, if_inst, if_valid} to IF/ID and obeys downstream stall and branch redirect.
module if_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  input  logic        stall_in,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic        icache_hit,
  input  logic [31:0] icache_val,
  input  logic [1:0]  status_if,
  input  logic [31:0] mem_data,
  output logic [31:0] pc_out,
  output logic        rw_if,
  output logic [31:0] addr_to_ctrl,
  output logic [31:0] if_pc,
  output logic [31:0] if_inst,
  output logic        if_valid
);

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_MISS  = 2'd1,
    S_PEND  = 2'd2,
    S_DRAIN = 2'd3
  } state_t;

  localparam logic [1:0] ST_IDLE    = 2'b00;
  localparam logic [1:0] ST_WORKING = 2'b01;
  localparam logic [1:0] ST_DONE    = 2'b10;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] if_pc_q, if_pc_d;
  logic [31:0] if_inst_q, if_inst_d;
  logic        if_valid_q, if_valid_d;
  logic [31:0] pend_inst_q, pend_inst_d;
  logic        pend_valid_q, pend_valid_d;

  logic accept;
  logic done;

  assign accept = !stall_in || !if_valid_q;
  assign done   = (status_if == ST_DONE);

  // The request drops combinationally in the DONE cycle. A registered drop
  // would still be high when the controller returns to IDLE, and the controller
  // would then launch a duplicate fetch. Reset forces state_q to FETCH, so the
  // request is also low while reset is held.
  assign rw_if        = (state_q == S_MISS) && !done;
  assign pc_out       = pc_q;
  assign addr_to_ctrl = pc_q;
  assign if_pc        = if_pc_q;
  assign if_inst      = if_inst_q;
  assign if_valid     = if_valid_q;

  // Next-state and datapath selection; redirect outranks every state rule.
  always_comb begin
    // NOTE: every variable gets a default first, so no path leaves one
    // unassigned and no latch is inferred.
    state_d      = state_q;
    pc_d         = pc_q;
    if_pc_d      = if_pc_q;
    if_inst_d    = if_inst_q;
    if_valid_d   = if_valid_q;
    pend_inst_d  = pend_inst_q;
    pend_valid_d = pend_valid_q;

    if (branch_taken) begin
      if_valid_d   = 1'b0;
      pend_valid_d = 1'b0;
      pc_d         = branch_target;
      unique case (state_q)
        // A request may have been accepted at this very edge, so drain it.
        S_MISS:  state_d = done ? S_FETCH : S_DRAIN;
        // A fetch that is still in flight must finish before fetching resumes.
        S_DRAIN: state_d = (status_if == ST_WORKING) ? S_DRAIN : S_FETCH;
        default: state_d = S_FETCH;
      endcase
    end else begin
      unique case (state_q)
        S_FETCH: begin
          if (icache_hit) begin
            if (accept) begin
              if_inst_d  = icache_val;
              if_pc_d    = pc_q;
              if_valid_d = 1'b1;
              pc_d       = pc_q + 32'd4;
            end
          end else begin
            state_d = S_MISS;
            if (accept) if_valid_d = 1'b0;
          end
        end
        S_MISS: begin
          if (done) begin
            if (accept) begin
              if_inst_d  = mem_data;
              if_pc_d    = pc_q;
              if_valid_d = 1'b1;
              pc_d       = pc_q + 32'd4;
              state_d    = S_FETCH;
            end else begin
              // DONE lasts exactly one cycle, so the word is parked here.
              pend_inst_d  = mem_data;
              pend_valid_d = 1'b1;
              state_d      = S_PEND;
            end
          end else if (accept) begin
            // IF/ID has taken whatever was presented, so it must not replay.
            if_valid_d = 1'b0;
          end
        end
        S_PEND: begin
          if (accept && pend_valid_q) begin
            if_inst_d    = pend_inst_q;
            if_pc_d      = pc_q;
            if_valid_d   = 1'b1;
            pc_d         = pc_q + 32'd4;
            pend_valid_d = 1'b0;
            state_d      = S_FETCH;
          end
        end
        S_DRAIN: begin
          // IDLE here means the controller never accepted the request.
          if (done || status_if == ST_IDLE) state_d = S_FETCH;
        end
        default: state_d = S_FETCH;
      endcase
    end
  end

  // State registers: async reset; global ready freezes everything.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= S_FETCH;
      pc_q         <= RESET_PC;
      if_pc_q      <= 32'h0;
      if_inst_q    <= 32'h0;
      if_valid_q   <= 1'b0;
      pend_inst_q  <= 32'h0;
      pend_valid_q <= 1'b0;
    end else if (rdy) begin
      // NOTE: non-blocking assignments, so all registers update from the
      // same pre-edge values regardless of statement order.
      state_q      <= state_d;
      pc_q         <= pc_d;
      if_pc_q      <= if_pc_d;
      if_inst_q    <= if_inst_d;
      if_valid_q   <= if_valid_d;
      pend_inst_q  <= pend_inst_d;
      pend_valid_q <= pend_valid_d;
    end
  end

endmodule

// File: doc/if_fetch.md
Name: if_fetch

Overview:
- Instruction-fetch stage directly upstream of the memory controller.
- Owns the architectural PC and drives the controller's pc input, which feeds the icache lookup.
- Consumes the controller's same-cycle icache hit/value outputs; on a miss, issues a fetch request and collects the word when the controller reports DONE.
- Presents {if_pc, if_inst, if_valid} to the IF/ID register, honouring downstream stall and branch redirect.

Parameters:
- RESET_PC, 32'h0, PC value loaded at reset.

Ports:
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-low
- rdy  in  1  global ready; low freezes all state
- stall_in  in  1  IF/ID cannot accept this cycle
- branch_taken  in  1  redirect request from EX
- branch_target  in  32  redirect PC
- icache_hit  in  1  controller icache hit for pc_out, same cycle
- icache_val  in  32  instruction on hit
- status_if  in  2  controller fetch status: 00 IDLE, 01 WORKING, 10 DONE
- mem_data  in  32  controller data_out; valid in the DONE cycle
- pc_out  out  32  current PC to controller/icache
- rw_if  out  1  fetch request, combinational
- addr_to_ctrl  out  32  fetch address (equals pc_out)
- if_pc  out  32  PC of presented instruction
- if_inst  out  32  presented instruction
- if_valid  out  1  if_inst valid

Behaviour:
- Reset (rst=0, async): pc=RESET_PC, if_pc=0, if_inst=0, if_valid=0, pend_valid=0, state=FETCH. rw_if=0 while in reset.
- rdy=0: no register changes. rw_if keeps its combinational value; the controller is frozen too.
- accept = !stall_in || !if_valid.
- The redirect check is applied before any state rule below.
- FETCH:
  - If icache_hit && accept: at the edge, if_inst<=icache_val, if_pc<=pc, if_valid<=1, pc<=pc+4. Throughput is one instruction per cycle on hits.
  - If icache_hit && !accept: hold everything.
  - If !icache_hit: go to MISS. If accept, clear if_valid so the consumed instruction is not replayed.
- MISS:
  - rw_if = (status_if != DONE). It must be combinational so the request drops in the same cycle DONE is seen. A registered drop would let the controller's IDLE relaunch a duplicate fetch.
  - The controller may defer the request while servicing a data access. Stay in MISS.
  - On status_if==DONE with accept: if_inst<=mem_data, if_pc<=pc, if_valid<=1, pc<=pc+4, go to FETCH.
  - On status_if==DONE with !accept: pend_inst<=mem_data, pend_valid<=1, go to PEND. DONE lasts exactly one cycle and must not be lost.
- PEND:
  - rw_if=0.
  - When accept: present pend_inst/pc, pc<=pc+4, pend_valid<=0, go to FETCH.
- DRAIN:
  - rw_if=0.
  - status_if==WORKING: stay.
  - status_if==DONE or IDLE: discard and go to FETCH. IDLE here means the request was never accepted.
- Branch redirect (branch_taken=1, highest priority, regardless of stall_in):
  - Always: if_valid<=0, pend_valid<=0, pc<=branch_target.
  - FETCH or PEND: go to FETCH.
  - MISS with status_if==DONE that cycle: discard mem_data, go to FETCH.
  - MISS otherwise: go to DRAIN, since a request may have been accepted at this very edge.
- Arithmetic: pc+4 is modulo 2^32. 32'hFFFFFFFC wraps to 0. No alignment check is made.
- pc_out=pc and addr_to_ctrl=pc at all times.

Test Plan:
- Reset with rst=0 mid-MISS -> pc=RESET_PC, if_valid=0, rw_if=0 immediately, without waiting for a clock edge.
- Hits at 0,4,8 with stall_in=0 -> if_pc 0,4,8 on consecutive cycles; pc=12 after 3 edges.
- Miss at 0x10, status_if IDLE,WORKING x4,DONE with mem_data=0x00A00093 -> rw_if=1 until the DONE cycle, 0 during DONE; then if_inst=0x00A00093, if_pc=0x10, pc=0x14; exactly one request issued.
- Miss with branch_taken=1, target=0x40 while status_if=WORKING -> DRAIN; returned word discarded, if_valid stays 0; next fetch at pc=0x40.
- DONE arrives while stall_in=1 and if_valid=1 -> PEND holds the word; stall released 3 cycles later -> word presented, pc advances by 4 once.
- rdy=0 for 5 cycles during a hit stream -> pc, if_* unchanged; stream resumes without skipping or duplicating.
